grid_reader: RTL and testbench

GRID_READER -- requirements
Module: grid_reader

---
 rtl/grid_reader.sv | 151 +++++++++++++++
 tb/tb_grid_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_reader.sv
// Purpose : walks a ROWS x COLS board row-major and emits one beat per cell on a valid/ready stream.
// Latency : first beat one cycle after start is sampled in IDLE; one beat per cycle while out_ready stays high.
// Backpres: out_valid && !out_ready stalls the walk and holds the beat payload unchanged.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous, active-low reset
//   board      - flattened board, cell (r,c) = board[r*COLS+c]
//   start      - request one full-board scan (only honoured in IDLE)
//   busy       - high while a scan is in progress
//   out_valid  - cell beat valid
//   out_ready  - downstream accepts the beat
//   out_cell   - alive bit of the current cell
//   out_row    - row index of the beat
//   out_col    - column index of the beat
//   out_last   - beat is cell (ROWS-1, COLS-1)
//   done       - one-cycle pulse after the last beat transfers
//
// Optional feature: define GRID_READER_SNAPSHOT_EN to capture the board when a
// scan starts and serve every beat from that copy. Without it, out_cell reads
// the live board at the current (row,col).

module grid_reader #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] board,
    input  logic                 start,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_cell,
    output logic [RW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic                 out_last,
    output logic                 done
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [IW-1:0]   idx;
    logic [N-1:0]    cell_src;
    logic            at_last;

    // Linear cell index of the current position; always in range because
    // row < ROWS and col < COLS are maintained by the walk.
    assign idx     = IW'(int'(row) * COLS + int'(col));
    assign at_last = (row == ROW_MAX) && (col == COL_MAX);

`ifdef GRID_READER_SNAPSHOT_EN
    logic [N-1:0] snap;

    // Captured on the same edge that leaves IDLE, so the whole scan sees one
    // consistent board regardless of later changes on the input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap <= '0;
        end else if (state == IDLE && start) begin
            snap <= board;
        end
    end

    assign cell_src = snap;
`else
    assign cell_src = board;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
        end
    end

    // All outputs are decoded from the registered state, so reset clears them
    // immediately and they are zero outside SCAN without extra gating.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_cell  = 1'b0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end

            SCAN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_cell  = cell_src[idx];
                out_row   = row;
                out_col   = col;
                out_last  = at_last;
                // start is deliberately not looked at here: no restart, no queuing.
                if (out_ready) begin
                    if (at_last) begin
                        state_nxt = DONE;
                    end else if (col == COL_MAX) begin
                        col_nxt = '0;
                        row_nxt = row + RW'(1);
                    end else begin
                        col_nxt = col + CW'(1);
                    end
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_grid_reader.sv
module tb_grid_reader;

    logic        clk;
    logic        reset;

    // 4x4 instance
    logic [15:0] board4;
    logic        start4;
    logic        busy4;
    logic        valid4;
    logic        ready4;
    logic        cell4;
    logic [1:0]  row4;
    logic [1:0]  col4;
    logic        last4;
    logic        done4;

    // 1x1 instance
    logic [0:0]  board1;
    logic        start1;
    logic        busy1;
    logic        valid1;
    logic        ready1;
    logic        cell1;
    logic [0:0]  row1;
    logic [0:0]  col1;
    logic        last1;
    logic        done1;

    int checks = 0;
    int errors = 0;

    grid_reader #(.ROWS(4), .COLS(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .board     (board4),
        .start     (start4),
        .busy      (busy4),
        .out_valid (valid4),
        .out_ready (ready4),
        .out_cell  (cell4),
        .out_row   (row4),
        .out_col   (col4),
        .out_last  (last4),
        .done      (done4)
    );

    grid_reader #(.ROWS(1), .COLS(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .board     (board1),
        .start     (start1),
        .busy      (busy1),
        .out_valid (valid1),
        .out_ready (ready1),
        .out_cell  (cell1),
        .out_row   (row1),
        .out_col   (col1),
        .out_last  (last1),
        .done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start4 for one sampled edge; returns at the negedge where the
    // first beat is expected to be on the bus.
    task automatic kick4();
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // Walk one 4x4 scan, checking every visible beat against the expected
    // row-major order. stall: ready follows 1,0,0,1. poke: beat index at which
    // start is raised. chg: beat index at which board becomes all ones.
    // abort: beat index at which reset is asserted mid-cycle.
    task automatic scan4(input string tag, input logic [15:0] base, input bit stall,
                         input int poke, input int chg, input int abort);
        int beats = 0;
        int cyc = 0;
        int ri = 0;
        logic c;
        logic [7:0] obs;
        logic [7:0] exp;
        while (beats < 16 && cyc < 200) begin
            ready4 = stall ? ((ri % 4 == 0) || (ri % 4 == 3)) : 1'b1;
            ri++;
            start4 = (beats == poke);
            if (beats == chg) board4 = 16'hFFFF;
            if (beats == abort) begin
                reset = 1'b0;
                #1;
                chk($sformatf("%s abort outputs", tag),
                    32'({busy4, valid4, cell4, row4, col4, last4, done4}), 32'd0);
                start4 = 1'b0;
                return;
            end
            #1;
`ifdef GRID_READER_SNAPSHOT_EN
            c = base[beats];
`else
            c = (chg >= 0 && beats >= chg) ? 1'b1 : base[beats];
`endif
            exp = {2'b11, c, 2'(beats / 4), 2'(beats % 4), (beats == 15)};
            obs = {busy4, valid4, cell4, row4, col4, last4};
            chk($sformatf("%s beat %0d cyc %0d", tag, beats, cyc), 32'(obs), 32'(exp));
            if (ready4) beats++;
            @(negedge clk);
            cyc++;
        end
        start4 = 1'b0;
        ready4 = 1'b1;
        chk($sformatf("%s beat count", tag), 32'(beats), 32'd16);
        if (!stall) chk($sformatf("%s cycles", tag), 32'(cyc), 32'd16);
        #1;
        chk($sformatf("%s done pulse", tag), 32'({done4, valid4, busy4}), 32'b100);
        @(negedge clk);
        #1;
        chk($sformatf("%s idle after", tag), 32'({done4, valid4, busy4}), 32'b000);
        @(negedge clk);
        #1;
        chk($sformatf("%s no restart", tag), 32'({done4, valid4, busy4}), 32'b000);
    endtask

    initial begin
        reset  = 1'b0;
        board4 = 16'hA5C3;
        start4 = 1'b0;
        ready4 = 1'b1;
        board1 = 1'b1;
        start1 = 1'b0;
        ready1 = 1'b1;

        // Reset state, including start held high while in reset.
        repeat (2) @(negedge clk);
        start4 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        #1;
        chk("reset4 outputs", 32'({busy4, valid4, cell4, row4, col4, last4, done4}), 32'd0);
        chk("reset1 outputs", 32'({busy1, valid1, cell1, row1, col1, last1, done1}), 32'd0);
        start4 = 1'b0;
        start1 = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        #1;
        chk("idle after reset", 32'({busy4, valid4, done4}), 32'd0);

        // Back-to-back scan.
        kick4();
        scan4("b2b", 16'hA5C3, 1'b0, -1, -1, -1);

        // Stalled scan, ready 1,0,0,1.
        kick4();
        scan4("stall", 16'hA5C3, 1'b1, -1, -1, -1);

        // start raised on beat 5 is ignored.
        kick4();
        scan4("poke", 16'hA5C3, 1'b0, 4, -1, -1);

        // Reset mid-cycle during beat 7: no done, then rescan from (0,0).
        kick4();
        scan4("abort", 16'hA5C3, 1'b0, -1, -1, 6);
        @(negedge clk);
        #1;
        chk("abort hold 1", 32'({busy4, valid4, done4}), 32'd0);
        @(negedge clk);
        #1;
        chk("abort hold 2", 32'({busy4, valid4, done4}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort released idle", 32'({busy4, valid4, done4}), 32'd0);
        kick4();
        scan4("rescan", 16'hA5C3, 1'b0, -1, -1, -1);

        // Board changes to all ones after the scan has started.
        kick4();
        scan4("snapshot", 16'hA5C3, 1'b0, -1, 3, -1);
        board4 = 16'hA5C3;

        // 1x1 board with a one-cycle stall on its single beat.
        @(negedge clk);
        start1 = 1'b1;
        ready1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        #1;
        chk("1x1 stalled beat", 32'({busy1, valid1, cell1, row1, col1, last1, done1}), 32'b1110010);
        @(negedge clk);
        ready1 = 1'b1;
        #1;
        chk("1x1 beat", 32'({busy1, valid1, cell1, row1, col1, last1, done1}), 32'b1110010);
        @(negedge clk);
        #1;
        chk("1x1 done", 32'({busy1, valid1, done1}), 32'b001);
        @(negedge clk);
        #1;
        chk("1x1 idle", 32'({busy1, valid1, done1}), 32'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
